opl_lfo: RTL and testbench
==========================

Name: opl_lfo

Overview:
Shared low-frequency oscillator for the OPL2 operator pipeline. It generates the tremolo (AM) level and the vibrato (PM) position. Both oscillators advance once per sample, on the operator-0 slot. The tremolo is a parametrised up/down triangle driven by an explicit RISE/FALL state machine. The vibrato is an 8-position phase counter. Outputs feed the envelope (am_val) and phase (vib_pos) stages of every operator.

Parameters:
AM_VAL_WIDTH, 5, width of am_val; must hold TREM_PEAK.
TREM_PEAK, 26, triangle apex value; full tremolo period = 2*TREM_PEAK steps.
TREM_DIV, 256, samples per tremolo step (49716/13312 ≈ 3.7 Hz at defaults).
VIB_DIV, 1024, samples per vibrato position (49716/8192 ≈ 6.1 Hz at defaults).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
sample_clk_en  in  1  one-cycle strobe per operator slot period
op_num  in  `OP_NUM_WIDTH  current operator slot
lfo_clr  in  1  synchronous clear (test-register LFO reset)
dam  in  1  tremolo depth: 1 = full (4.8 dB), 0 = quarter (1 dB)
am_val  out  AM_VAL_WIDTH  registered tremolo attenuation
vib_pos  out  3  registered vibrato position 0..7
trem_dir  out  1  current triangle direction: 0 = RISE, 1 = FALL (debug/verification)

Behaviour:
- Reset, asynchronous: all prescalers 0, trem_level 0, state RISE, vib counter 0, am_val 0, vib_pos 0.
- Advance strobe adv = sample_clk_en && op_num == 0.
- Tremolo prescaler counts 0..TREM_DIV-1 on adv. It wraps to 0 and emits a one-cycle trem_tick at TREM_DIV-1.
- Tremolo FSM, evaluated on trem_tick:
  - RISE: trem_level += 1. On reaching TREM_PEAK, go to FALL on the same tick.
  - FALL: trem_level -= 1. On reaching 0, go to RISE.
  - Level sequence is 0,1,…,26,25,…,1,0,1,… with period 52 steps (13312 samples at defaults). The apex and zero each last exactly one step.
- Vibrato prescaler counts 0..VIB_DIV-1 on adv. On wrap, the vib counter increments modulo 8 with natural 3-bit wrap, 7→0.
- am_val is registered every clk from the current state, giving 1-cycle latency after a level change:
  - dam=1: trem_level.
  - dam=0: trem_level >> 2 (truncating; 26→6).
  - A dam change is visible on the next clk with no other side effect.
- vib_pos is the registered vib counter, also with 1-cycle latency.
- lfo_clr=1 clears both prescalers, trem_level, FSM (→RISE) and vib counter on the next clk edge. It has priority over a simultaneous adv/tick. am_val and vib_pos reach 0 one cycle later. While lfo_clr is held, the counters stay frozen at 0.
- Reset mid-period returns to the reset state immediately, with no glitch-dependency on sample_clk_en.
- adv when op_num≠0, or sample_clk_en low: counters hold.
- Arithmetic: trem_level never leaves 0..TREM_PEAK, and there is no modular wrap on the triangle.

Optional Feature:
Macro OPL_LFO_VIB_EN.
- Defined: vibrato prescaler and counter are built as described.
- Undefined: the vibrato logic is omitted, and vib_pos is a constant 0 (still reset-clean). Tremolo behaviour is identical in both builds.

Decomposition:
- Shared header opl.vh: `OP_NUM_WIDTH, `AM_VAL_WIDTH, plus new defaults `LFO_TREM_PEAK, `LFO_TREM_DIV, `LFO_VIB_DIV, and the RISE/FALL state encodings.
- Sub-module opl_lfo_prescaler: parameter DIV, inputs clk/rst/en/clr, output tick. Instantiated twice, for tremolo and vibrato; the vibrato instance is only built under OPL_LFO_VIB_EN.

Test Plan:
1. Reset, then 13312 adv strobes with dam=1 -> am_val rises 0→26 at one step per 256 samples and falls back to 0. trem_dir toggles to 1 on reaching 26 and to 0 on reaching 0. The sequence repeats exactly.
2. dam=0 at trem_level 26 -> am_val=6 one clk later. At level 3, am_val=0. Toggling dam back to 1 restores 26/3 one clk later.
3. sample_clk_en pulses with op_num cycling 0..17 -> counters advance only on op_num=0. 1024 such frames advance vib_pos by 1, and 8192 frames wrap vib_pos 7→0.
4. lfo_clr asserted in the same cycle as a trem_tick at level 13 RISE -> next state is level 0, RISE. am_val=0 and vib_pos=0 the following cycle, and counters stay 0 while lfo_clr is held.
5. Async rst asserted mid-FALL between clock edges -> am_val, vib_pos and trem_dir go to 0 immediately. After release, the first trem_tick produces am_val=1.
6. Build without OPL_LFO_VIB_EN, run scenario 1 -> identical am_val trace, and vib_pos constantly 0.

Source files
------------

// File: rtl/opl_lfo_pkg.sv
// rtl/opl_lfo_pkg.sv - shared OPL2 LFO widths, default rates and tremolo state encodings
package opl_lfo_pkg;

  localparam int OP_NUM_WIDTH  = 5;
  localparam int AM_VAL_WIDTH  = 5;

  localparam int LFO_TREM_PEAK = 26;
  localparam int LFO_TREM_DIV  = 256;
  localparam int LFO_VIB_DIV   = 1024;

  localparam logic [0:0] TREM_RISE = 1'b0;
  localparam logic [0:0] TREM_FALL = 1'b1;

endpackage

// File: rtl/opl_lfo_if.sv
// rtl/opl_lfo_if.sv - slot strobe/control inputs and AM/PM outputs of the shared LFO
interface opl_lfo_if
  import opl_lfo_pkg::*;
#(
  parameter int AM_W = AM_VAL_WIDTH
);
  logic                    sample_clk_en;
  logic [OP_NUM_WIDTH-1:0] op_num;
  logic                    lfo_clr;
  logic                    dam;
  logic [AM_W-1:0]         am_val;
  logic [2:0]              vib_pos;
  logic                    trem_dir;

  modport master (
    output sample_clk_en, op_num, lfo_clr, dam,
    input  am_val, vib_pos, trem_dir
  );

  modport slave (
    input  sample_clk_en, op_num, lfo_clr, dam,
    output am_val, vib_pos, trem_dir
  );
endinterface

// File: rtl/opl_lfo_prescaler.sv
// rtl/opl_lfo_prescaler.sv - divide-by-DIV sample counter emitting a one-cycle tick on its last count
module opl_lfo_prescaler #(
  parameter int DIV = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // clr wins over a coincident tick so the consumer never sees a step on the clear edge
  assign tick = en && !clr && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end
endmodule

// File: rtl/opl_lfo.sv
// rtl/opl_lfo.sv - shared OPL2 tremolo triangle and vibrato position; OPL_LFO_VIB_EN builds vibrato
module opl_lfo
  import opl_lfo_pkg::*;
#(
  parameter int AM_VAL_WIDTH = opl_lfo_pkg::AM_VAL_WIDTH,
  parameter int TREM_PEAK    = LFO_TREM_PEAK,
  parameter int TREM_DIV     = LFO_TREM_DIV,
  parameter int VIB_DIV      = LFO_VIB_DIV
) (
  input logic        clk,
  input logic        rst,
  opl_lfo_if.slave   lfo
);
  localparam logic [AM_VAL_WIDTH-1:0] PEAK_M1 = AM_VAL_WIDTH'(TREM_PEAK - 1);
  localparam logic [AM_VAL_WIDTH-1:0] ONE     = AM_VAL_WIDTH'(1);

  logic                    adv;
  logic                    trem_tick;
  logic [AM_VAL_WIDTH-1:0] trem_level;
  logic [0:0]              trem_state;

  assign adv = lfo.sample_clk_en && (lfo.op_num == '0);

  opl_lfo_prescaler #(.DIV(TREM_DIV)) u_trem_pre (
    .clk  (clk),
    .rst  (rst),
    .en   (adv),
    .clr  (lfo.lfo_clr),
    .tick (trem_tick)
  );

  // Direction flips on the same tick that lands on the apex or zero, so each lasts one step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trem_level <= '0;
      trem_state <= TREM_RISE;
    end else if (lfo.lfo_clr) begin
      trem_level <= '0;
      trem_state <= TREM_RISE;
    end else if (trem_tick) begin
      case (trem_state)
        TREM_RISE: begin
          trem_level <= trem_level + 1'b1;
          if (trem_level == PEAK_M1) trem_state <= TREM_FALL;
        end
        default: begin
          trem_level <= trem_level - 1'b1;
          if (trem_level == ONE) trem_state <= TREM_RISE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfo.am_val <= '0;
    end else begin
      lfo.am_val <= lfo.dam ? trem_level : (trem_level >> 2);
    end
  end

  assign lfo.trem_dir = (trem_state == TREM_FALL);

`ifdef OPL_LFO_VIB_EN
  logic       vib_tick;
  logic [2:0] vib_cnt;

  opl_lfo_prescaler #(.DIV(VIB_DIV)) u_vib_pre (
    .clk  (clk),
    .rst  (rst),
    .en   (adv),
    .clr  (lfo.lfo_clr),
    .tick (vib_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vib_cnt     <= '0;
      lfo.vib_pos <= '0;
    end else begin
      if (lfo.lfo_clr) begin
        vib_cnt <= '0;
      end else if (vib_tick) begin
        vib_cnt <= vib_cnt + 1'b1;
      end
      lfo.vib_pos <= vib_cnt;
    end
  end
`else
  localparam int unused_vib_div = VIB_DIV;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfo.vib_pos <= '0;
    end else begin
      lfo.vib_pos <= '0;
    end
  end
`endif
endmodule

// File: tb/tb_opl_lfo.sv
// tb/tb_opl_lfo.sv - scoreboard bench for opl_lfo tremolo triangle, dam scaling, clear, reset and vibrato
module tb_opl_lfo;
  import opl_lfo_pkg::*;

  localparam int PEAK   = 26;
  localparam int TDIV   = 256;
  localparam int VDIV   = 1024;
  localparam int PERIOD = 2 * PEAK;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  opl_lfo_if #(.AM_W(5)) lfo ();

  opl_lfo #(
    .AM_VAL_WIDTH (5),
    .TREM_PEAK    (PEAK),
    .TREM_DIV     (TDIV),
    .VIB_DIV      (VDIV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .lfo (lfo)
  );

  typedef struct packed {
    logic [4:0] am;
    logic [2:0] vib;
    logic       dir;
  } obs_t;

  obs_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   m_adv   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference triangle derived from the number of advances since the last clear
  function automatic int ref_level(input int a);
    int m;
    m = (a / TDIV) % PERIOD;
    return (m <= PEAK) ? m : PERIOD - m;
  endfunction

  function automatic logic ref_dir(input int a);
    return ((a / TDIV) % PERIOD) >= PEAK;
  endfunction

  function automatic logic [2:0] ref_vib(input int a);
`ifdef OPL_LFO_VIB_EN
    return 3'((a / VDIV) % 8);
`else
    return 3'(a - a);
`endif
  endfunction

  task automatic step(input logic sce, input logic [4:0] op, input logic clr,
                      input logic dam, input string tag);
    obs_t e;
    obs_t o;
    obs_t got;
    lfo.sample_clk_en = sce;
    lfo.op_num        = op;
    lfo.lfo_clr       = clr;
    lfo.dam           = dam;
    e.am  = dam ? 5'(ref_level(m_adv)) : 5'(ref_level(m_adv) >> 2);
    e.vib = ref_vib(m_adv);
    if (clr) m_adv = 0;
    else if (sce && op == 5'd0) m_adv++;
    e.dir = ref_dir(m_adv);
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    o = exp_q.pop_front();
    got.am  = lfo.am_val;
    got.vib = lfo.vib_pos;
    got.dir = lfo.trem_dir;
    check_val(tag, 32'(got), 32'(o));
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    lfo.sample_clk_en = 1'b0;
    lfo.op_num        = '0;
    lfo.lfo_clr       = 1'b0;
    lfo.dam           = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_am",  32'(lfo.am_val),   32'd0);
    check_val("rst_vib", 32'(lfo.vib_pos),  32'd0);
    check_val("rst_dir", 32'(lfo.trem_dir), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 2 * PERIOD * TDIV; i++) step(1'b1, 5'd0, 1'b0, 1'b1, "trem");

    repeat (3 * TDIV) step(1'b1, 5'd0, 1'b0, 1'b1, "to_l3");
    step(1'b0, 5'd0, 1'b0, 1'b0, "dam0_l3");
    step(1'b0, 5'd0, 1'b0, 1'b1, "dam1_l3");
    repeat (23 * TDIV) step(1'b1, 5'd0, 1'b0, 1'b1, "to_l26");
    step(1'b0, 5'd0, 1'b0, 1'b0, "dam0_l26");
    step(1'b0, 5'd0, 1'b0, 1'b0, "dam0_hold");
    step(1'b0, 5'd0, 1'b0, 1'b1, "dam1_l26");

    repeat (4 * TDIV) step(1'b1, 5'd0, 1'b0, 1'b1, "to_fall");
    #2 rst = 1'b1;
    #1;
    check_val("arst_am",  32'(lfo.am_val),   32'd0);
    check_val("arst_vib", 32'(lfo.vib_pos),  32'd0);
    check_val("arst_dir", 32'(lfo.trem_dir), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst   = 1'b0;
    m_adv = 0;
    repeat (TDIV) step(1'b1, 5'd0, 1'b0, 1'b1, "post_rst");
    step(1'b0, 5'd0, 1'b0, 1'b1, "post_rst_am1");

    while (m_adv < 14 * TDIV - 1) step(1'b1, 5'd0, 1'b0, 1'b1, "to_l13");
    step(1'b1, 5'd0, 1'b1, 1'b1, "clr_tick");
    repeat (4) step(1'b1, 5'd0, 1'b1, 1'b1, "clr_hold");

    for (int f = 0; f < VDIV; f++) begin
      for (int op = 0; op < 18; op++) begin
        step((op == 0) ? 1'b1 : 1'($urandom_range(0, 1)), 5'(op), 1'b0, 1'b1, "frame");
      end
    end
    while (m_adv < 8 * VDIV + 2) step(1'b1, 5'd0, 1'b0, 1'b1, "vib_wrap");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
